regfile_ctrl: RTL and testbench

Moore state-machine controller that sequences the eight-entry, 16-bit register file and its surrounding datapath (A/B operand registers, shifter, ALU, C result register, status register) for one instruction at a time. A decoded instruction arrives with a start pulse. The block then drives the register read/write selects and the pipeline-register load enables for the required cycles. It returns to idle with `w` high. It sits between the instruction decoder and the datapath that contains the register file.

---
 rtl/regfile_ctrl.sv | 127 ++++++++++++
 tb/tb_regfile_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// Moore sequencer for the 8x16 register file datapath; one instruction at a time.
// Optional REGFILE_CTRL_ILLEGAL_EN: illegal codes latch a sticky ERR state instead of a one-cycle no-op.
module regfile_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] aluop,
  output logic       err
);
`ifdef REGFILE_CTRL_ILLEGAL_EN
  localparam logic ILL_STICKY = 1'b1;
`else
  localparam logic ILL_STICKY = 1'b0;
`endif

  // ST_BAD is the sticky ERR state when enabled, otherwise a silent one-cycle no-op.
  typedef enum logic [2:0] {
    ST_WAIT, ST_WIMM, ST_GETA, ST_GETB, ST_ALU, ST_CMP, ST_WREG, ST_BAD
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] aluop;
    logic       err;
  } ctl_t;

  state_t     state, nxt;
  logic [2:0] opc_q, opc_n;
  logic [1:0] op_q, op_n;
  ctl_t       ctl_q;

  function automatic ctl_t ctl_of(input state_t st, input logic [2:0] opc, input logic [1:0] o);
    ctl_t c;
    logic movreg;
    c      = '0;
    movreg = (opc == 3'b110) && (o == 2'b00);
    c.aluop = movreg ? 2'b00 : o;
    case (st)
      ST_WAIT: c.w = 1'b1;
      ST_WIMM: begin c.nsel = 3'b001; c.vsel = 1'b1; c.write = 1'b1; end
      ST_GETA: begin c.nsel = 3'b001; c.loada = 1'b1; end
      ST_GETB: begin c.nsel = 3'b100; c.loadb = 1'b1; end
      ST_ALU:  begin c.loadc = 1'b1; c.asel = movreg; end
      ST_CMP:  begin c.loads = 1'b1; c.aluop = 2'b01; end
      ST_WREG: begin c.nsel = 3'b010; c.write = 1'b1; end
      ST_BAD:  c.err = ILL_STICKY;
      default: c.w = 1'b1;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt   = state;
    opc_n = opc_q;
    op_n  = op_q;
    case (state)
      ST_WAIT: if (s) begin
        opc_n = opcode;
        op_n  = op;
        case ({opcode, op})
          5'b110_10:                     nxt = ST_WIMM;
          5'b110_00, 5'b101_11:          nxt = ST_GETB;
          5'b101_00, 5'b101_10, 5'b101_01: nxt = ST_GETA;
          default:                       nxt = ST_BAD;
        endcase
      end
      ST_WIMM: nxt = ST_WAIT;
      ST_GETA: nxt = ST_GETB;
      // Compare skips the C-register load and the writeback.
      ST_GETB: nxt = (opc_q == 3'b101 && op_q == 2'b01) ? ST_CMP : ST_ALU;
      ST_ALU:  nxt = ST_WREG;
      ST_CMP:  nxt = ST_WAIT;
      ST_WREG: nxt = ST_WAIT;
      ST_BAD:  nxt = ILL_STICKY ? ST_BAD : ST_WAIT;
      default: nxt = ST_WAIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_WAIT;
      opc_q <= 3'b000;
      op_q  <= 2'b00;
      ctl_q <= ctl_of(ST_WAIT, 3'b000, 2'b00);
    end else begin
      state <= nxt;
      opc_q <= opc_n;
      op_q  <= op_n;
      ctl_q <= ctl_of(nxt, opc_n, op_n);
    end
  end

  assign w     = ctl_q.w;
  assign nsel  = ctl_q.nsel;
  assign vsel  = ctl_q.vsel;
  assign write = ctl_q.write;
  assign loada = ctl_q.loada;
  assign loadb = ctl_q.loadb;
  assign loadc = ctl_q.loadc;
  assign loads = ctl_q.loads;
  assign asel  = ctl_q.asel;
  assign bsel  = ctl_q.bsel;
  assign aluop = ctl_q.aluop;
  assign err   = ctl_q.err;
endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: per-cycle output vector checks across every instruction path.
module tb_regfile_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic       w, vsel, write, loada, loadb, loadc, loads, asel, bsel, err;
  logic [2:0] nsel;
  logic [1:0] aluop;
  int checks = 0;
  int errors = 0;

  regfile_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .aluop(aluop), .err(err)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, aluop, err};

  // Fields: w, nsel, vsel, write, loada, loadb, loadc, loads, asel, aluop, err (bsel always 0).
  function automatic logic [14:0] mk(input logic ww, input logic [2:0] n, input logic vs, input logic wr,
                                     input logic la, input logic lb, input logic lc, input logic ls,
                                     input logic as, input logic [1:0] al, input logic e);
    return {ww, n, vs, wr, la, lb, lc, ls, as, 1'b0, al, e};
  endfunction

  function automatic logic [14:0] st_wait(input logic [1:0] al);
    return mk(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, al, 0);
  endfunction
  function automatic logic [14:0] st_wimm(input logic [1:0] al);
    return mk(0, 3'b001, 1, 1, 0, 0, 0, 0, 0, al, 0);
  endfunction
  function automatic logic [14:0] st_geta(input logic [1:0] al);
    return mk(0, 3'b001, 0, 0, 1, 0, 0, 0, 0, al, 0);
  endfunction
  function automatic logic [14:0] st_getb(input logic [1:0] al);
    return mk(0, 3'b100, 0, 0, 0, 1, 0, 0, 0, al, 0);
  endfunction
  function automatic logic [14:0] st_alu(input logic [1:0] al, input logic as);
    return mk(0, 3'b000, 0, 0, 0, 0, 1, 0, as, al, 0);
  endfunction
  function automatic logic [14:0] st_wreg(input logic [1:0] al);
    return mk(0, 3'b010, 0, 1, 0, 0, 0, 0, 0, al, 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held two cycles
    tick(); tick();
    chk("reset", st_wait(2'b00));
    reset_n = 1'b1;
    tick();
    chk("idle", st_wait(2'b00));

    // MOV R3,#42: one write cycle
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    tick(); chk("movi_wimm", st_wimm(2'b10));
    s = 1'b0;
    tick(); chk("movi_wait", st_wait(2'b10));

    // ADD, with inputs changed mid-instruction and a stray s pulse
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    tick(); chk("add_geta", st_geta(2'b00));
    s = 1'b0; opcode = 3'b110; op = 2'b11;
    tick(); chk("add_getb", st_getb(2'b00));
    s = 1'b1;
    tick(); chk("add_alu", st_alu(2'b00, 0));
    s = 1'b0;
    tick(); chk("add_wreg", st_wreg(2'b00));
    tick(); chk("add_wait", st_wait(2'b00));
    tick(); chk("add_no_requeue", st_wait(2'b00));

    // AND
    opcode = 3'b101; op = 2'b10; s = 1'b1;
    tick(); chk("and_geta", st_geta(2'b10));
    s = 1'b0;
    tick(); chk("and_getb", st_getb(2'b10));
    tick(); chk("and_alu", st_alu(2'b10, 0));
    tick(); chk("and_wreg", st_wreg(2'b10));
    tick(); chk("and_wait", st_wait(2'b10));

    // CMP: status load, no write
    opcode = 3'b101; op = 2'b01; s = 1'b1;
    tick(); chk("cmp_geta", st_geta(2'b01));
    s = 1'b0;
    tick(); chk("cmp_getb", st_getb(2'b01));
    tick(); chk("cmp_cmp", mk(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0));
    tick(); chk("cmp_wait", st_wait(2'b01));

    // MOV Rd,Rm: asel forces zero on A
    opcode = 3'b110; op = 2'b00; s = 1'b1;
    tick(); chk("movr_getb", st_getb(2'b00));
    s = 1'b0;
    tick(); chk("movr_alu", st_alu(2'b00, 1));
    tick(); chk("movr_wreg", st_wreg(2'b00));
    tick(); chk("movr_wait", st_wait(2'b00));

    // MVN
    opcode = 3'b101; op = 2'b11; s = 1'b1;
    tick(); chk("mvn_getb", st_getb(2'b11));
    s = 1'b0;
    tick(); chk("mvn_alu", st_alu(2'b11, 0));
    tick(); chk("mvn_wreg", st_wreg(2'b11));
    tick(); chk("mvn_wait", st_wait(2'b11));

    // Back-to-back MOV imm with s held high
    opcode = 3'b110; op = 2'b10; s = 1'b1;
    tick(); chk("b2b_wimm0", st_wimm(2'b10));
    tick(); chk("b2b_wait", st_wait(2'b10));
    tick(); chk("b2b_wimm1", st_wimm(2'b10));
    s = 1'b0;
    tick(); chk("b2b_end", st_wait(2'b10));

    // Reset during GET_B of ADD
    opcode = 3'b101; op = 2'b00; s = 1'b1;
    tick(); chk("rst_geta", st_geta(2'b00));
    s = 1'b0;
    tick(); chk("rst_getb", st_getb(2'b00));
    reset_n = 1'b0;
    tick(); chk("rst_mid", st_wait(2'b00));
    reset_n = 1'b1;
    tick(); chk("rst_after", st_wait(2'b00));

    // Illegal instruction
    opcode = 3'b000; op = 2'b11; s = 1'b1;
    tick();
`ifdef REGFILE_CTRL_ILLEGAL_EN
    chk("ill_err", mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1));
    opcode = 3'b110; op = 2'b10;
    tick(); chk("ill_hold0", mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1));
    s = 1'b0;
    tick(); chk("ill_hold1", mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1));
    reset_n = 1'b0;
    tick(); chk("ill_reset", st_wait(2'b00));
    reset_n = 1'b1;
    tick(); chk("ill_after", st_wait(2'b00));
`else
    chk("ill_nop", mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0));
    s = 1'b0;
    tick(); chk("ill_wait", st_wait(2'b11));
    opcode = 3'b110; op = 2'b01; s = 1'b1;
    tick(); chk("ill2_nop", mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0));
    s = 1'b0;
    tick(); chk("ill2_wait", st_wait(2'b01));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
